lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store stage of the multi-cycle core. Accepts one instruction from the execute stage through a valid/ready handshake, performs at most one memory access on the data bus (load with byte/half extraction and sign/zero extension, or store with byte strobes), and presents the writeback payload to the writeback stage. Control is a Moore FSM, so every handshake output depends only on state, and it drives the master side of the writeback stage interface.

## Interface
- No parameters (XLEN fixed at 32).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  stage can accept
- in_inst_valid  in  1  payload is a real instruction (0 = bubble)
- in_mem_en  in  1  instruction accesses memory
- in_mem_wen  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32 load/store funct3
- in_addr  in  32  effective address
- in_wdata  in  32  store data (rs2)
- in_alu_result  in  32  non-memory result
- in_rd_addr  in  5  destination register
- in_reg_wen  in  1  register write enable
- in_pc_target  in  32  next PC
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  word-aligned address
- mem_req_wen  out  1  write request
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes (0000 for loads)
- mem_resp_valid  in  1  bus response
- mem_resp_rdata  in  32  read data
- mem_resp_err  in  1  bus error
- out_valid  out  1  payload offered to writeback
- out_ready  in  1  writeback accepts
- out_payload_valid  out  1  payload is a real instruction
- out_rd_addr  out  5
- out_wb_data  out  32
- out_reg_wen  out  1
- out_pc_target  out  32
- out_err  out  1  bus error occurred on this instruction

## Operation
- Registers: input payload latched on in_valid && in_ready; load data and error latched on mem_resp_valid in S_WAIT.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT.
  - S_IDLE: in_ready=1. On fire: a bubble (in_inst_valid=0) is dropped and the FSM stays in S_IDLE. A memory instruction goes to S_REQ. Anything else goes to S_OUT.
  - S_REQ: mem_req_valid=1. On mem_req_ready, go to S_WAIT. Stores also wait for their acknowledge.
  - S_WAIT: on mem_resp_valid, go to S_OUT. Responses are ignored in any other state.
  - S_OUT: out_valid=1, out_payload_valid=1. On out_ready, go to S_IDLE.
- mem_req_addr = {in_addr[31:2],2'b00}. Byte lane = addr[1:0]; half lane = addr[1]. Misalignment is not checked: lane bits are used as-is, and a word access ignores addr[1:0].
- Store strobes and data:
  - sb: wstrb = 0001<<addr[1:0]; wdata = byte replicated into all 4 lanes.
  - sh: wstrb = 0011<<(2*addr[1]); wdata = half replicated into both halves.
  - sw: wstrb = 1111.
- Load extension:
  - lb/lbu: sign/zero-extend the selected byte.
  - lh/lhu: sign/zero-extend the selected half.
  - lw: full word. funct3 011/110/111 are treated as lw.
- out_wb_data: extended load data for loads; in_alu_result (latched) otherwise.
- Bus error: out_err=1, out_wb_data=0, out_reg_wen forced 0. out_pc_target is unchanged.
- All out_* payload signals are stable while out_valid=1. mem_req_* signals are stable while mem_req_valid=1.

## Timing
- Reset: state S_IDLE. All payload registers = 0. mem_req_valid=0, out_valid=0, out_payload_valid=0, out_err=0. in_ready=1 from the first cycle after reset is released.
- Reset asserted mid-operation aborts immediately with no output. An outstanding bus transaction is abandoned; the bus must tolerate this.
- Non-memory instruction: accepted at cycle N, out_valid at N+1.
- Memory instruction, zero-wait bus: accepted at N, mem_req_valid at N+1, response at N+2, out_valid at N+3.
- Throughput: at most one instruction in flight. in_ready=0 in every state except S_IDLE, so the earliest next accept is the cycle after out fire.
- Back-pressure: out_ready=0 holds S_OUT indefinitely. mem_req_ready=0 holds S_REQ indefinitely.

## Test plan
- Non-memory op: alu_result=0x1234, rd=5, reg_wen=1, no stall -> out_valid exactly one cycle after accept; wb_data=0x1234, reg_wen=1; in_ready returns to 1 the cycle after out fire.
- Byte loads: mem word 0x80FF7F01, addr=0x1003 lb -> wb_data=0xFFFFFF80; same address lbu -> 0x00000080; addr=0x1002 lh -> 0xFFFF80FF; mem_req_addr=0x1000 in all cases.
- Stores: sb 0xAB at 0x2001 -> wstrb=0010, wdata=0xABABABAB; sh 0xBEEF at 0x2002 -> wstrb=1100, wdata=0xBEEFBEEF; wb reg_wen as supplied (0).
- Stalls: mem_req_ready held low 3 cycles, then response delayed 2 cycles, then out_ready held low 4 cycles -> request and output signals stay stable throughout; exactly one out fire; in_ready=0 for the whole period.
- Bubble and error: an in_inst_valid=0 offer is accepted and produces no out_valid; a load with mem_resp_err=1 -> out_err=1, wb_data=0, reg_wen=0.
- Reset mid-S_WAIT: all valids are 0 on the next cycle and in_ready=1; a later mem_resp_valid is ignored.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage - load/store stage of the multi-cycle core.
//
// Accepts one instruction from execute (valid/ready), performs at most one
// data-bus access (load with byte/half extraction and extension, or store
// with byte strobes), then offers the writeback payload to writeback.
// Only one instruction is in flight at a time. Every handshake output is a
// registered function of the FSM state.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      execute-side handshake
//   in_inst_valid            payload is a real instruction (0 = bubble, dropped)
//   in_mem_en, in_mem_wen    memory access enable; 1 = store, 0 = load
//   in_funct3                RV32 load/store width/sign selector
//   in_addr, in_wdata        effective address and store data (rs2)
//   in_alu_result            result for non-load instructions
//   in_rd_addr, in_reg_wen   destination register and its write enable
//   in_pc_target             next PC, passed through untouched
//   mem_req_*                bus request: word-aligned address, write flag,
//                            lane-replicated write data, byte strobes
//   mem_resp_*               bus response: read data and error flag
//   out_valid / out_ready    writeback-side handshake
//   out_payload_valid        payload is a real instruction
//   out_rd_addr, out_wb_data, out_reg_wen, out_pc_target, out_err
//                            writeback payload; a bus error zeroes the data
//                            and suppresses the register write

module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_inst_valid,
    input  logic        in_mem_en,
    input  logic        in_mem_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_rd_addr,
    input  logic        in_reg_wen,
    input  logic [31:0] in_pc_target,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_payload_valid,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_wb_data,
    output logic        out_reg_wen,
    output logic [31:0] out_pc_target,
    output logic        out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        in_ready_r;
    logic        mem_req_valid_r;
    logic        out_valid_r;

    logic        mem_en_r;
    logic        mem_wen_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] alu_r;
    logic [4:0]  rd_r;
    logic        reg_wen_r;
    logic [31:0] pc_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        accept_s;
    logic [31:0] wb_data_s;

    // Byte strobes for a store; funct3[1:0] encodes the width, 11 acts as a word.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data replicated into every lane so the strobes alone pick the bytes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] data;
        case (f3[1:0])
            2'b00:   data = {4{wd[7:0]}};
            2'b01:   data = {2{wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

    // Lane extraction and extension of a load; unknown widths fall back to a word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] data;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  data = {{24{b[7]}}, b};
            3'b001:  data = {{16{h[15]}}, h};
            3'b100:  data = {24'd0, b};
            3'b101:  data = {16'd0, h};
            default: data = word;
        endcase
        return data;
    endfunction

    assign accept_s = in_valid && in_ready_r;

    // Next-state logic of the control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && in_inst_valid) begin
                    state_s = in_mem_en ? S_REQ : S_OUT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            in_ready_r      <= 1'b1;
            mem_req_valid_r <= 1'b0;
            out_valid_r     <= 1'b0;
        end else begin
            state_r         <= state_s;
            in_ready_r      <= (state_s == S_IDLE);
            mem_req_valid_r <= (state_s == S_REQ);
            out_valid_r     <= (state_s == S_OUT);
        end
    end

    // Payload capture on accept; response data and error captured in S_WAIT only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_r  <= 1'b0;
            mem_wen_r <= 1'b0;
            funct3_r  <= 3'd0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            alu_r     <= 32'd0;
            rd_r      <= 5'd0;
            reg_wen_r <= 1'b0;
            pc_r      <= 32'd0;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else if (accept_s) begin
            mem_en_r  <= in_mem_en;
            mem_wen_r <= in_mem_wen;
            funct3_r  <= in_funct3;
            addr_r    <= in_addr;
            wdata_r   <= in_wdata;
            alu_r     <= in_alu_result;
            rd_r      <= in_rd_addr;
            reg_wen_r <= in_reg_wen;
            pc_r      <= in_pc_target;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else if ((state_r == S_WAIT) && mem_resp_valid) begin
            rdata_r   <= mem_resp_rdata;
            err_r     <= mem_resp_err;
        end
    end

    // Writeback data: zero on error, extended read data for loads, ALU result otherwise.
    always_comb begin
        wb_data_s = alu_r;
        if (err_r) begin
            wb_data_s = 32'd0;
        end else if (mem_en_r && !mem_wen_r) begin
            wb_data_s = load_extend(funct3_r, addr_r[1:0], rdata_r);
        end else begin
            wb_data_s = alu_r;
        end
    end

    assign in_ready          = in_ready_r;
    assign mem_req_valid     = mem_req_valid_r;
    assign mem_req_addr      = {addr_r[31:2], 2'b00};
    assign mem_req_wen       = mem_wen_r;
    assign mem_req_wdata     = store_data(funct3_r, wdata_r);
    assign mem_req_wstrb     = mem_wen_r ? store_strb(funct3_r, addr_r[1:0]) : 4'b0000;
    assign out_valid         = out_valid_r;
    assign out_payload_valid = out_valid_r;
    assign out_rd_addr       = rd_r;
    assign out_wb_data       = wb_data_s;
    assign out_reg_wen       = reg_wen_r & ~err_r;
    assign out_pc_target     = pc_r;
    assign out_err           = err_r;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_inst_valid;
    logic        in_mem_en;
    logic        in_mem_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rd_addr;
    logic        in_reg_wen;
    logic [31:0] in_pc_target;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic        out_payload_valid;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_wb_data;
    logic        out_reg_wen;
    logic [31:0] out_pc_target;
    logic        out_err;

    int n_cmp = 0;
    int n_err = 0;

    logic        r_iv, r_me, r_we, r_rw, r_err;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [31:0] r_addr, r_wd, r_alu, r_pc, r_word;

    lsu_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst_valid(in_inst_valid),
        .in_mem_en(in_mem_en), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
        .in_rd_addr(in_rd_addr), .in_reg_wen(in_reg_wen), .in_pc_target(in_pc_target),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload_valid(out_payload_valid),
        .out_rd_addr(out_rd_addr), .out_wb_data(out_wb_data), .out_reg_wen(out_reg_wen),
        .out_pc_target(out_pc_target), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load result from the word, width/sign code and byte address.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int unsigned b;
        int unsigned h;
        int          v;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0: begin v = int'(b); if (v >= 128) v = v - 256; return 32'(v); end
            3'd1: begin v = int'(h); if (v >= 32768) v = v - 65536; return 32'(v); end
            3'd4: return b;
            3'd5: return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 4'(1 << addr[1:0]);
            3'd1:    return 4'(3 << (2 * addr[1]));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h01010101;
            3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // Offers one instruction at a negedge, then walks it through the stage
    // with the given request stall, response delay and output back-pressure.
    task automatic run_inst(input logic iv, input logic me, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                            input logic [4:0] rd, input logic rw, input logic [31:0] pc,
                            input logic [31:0] word, input logic err,
                            input int req_stall, input int resp_dly, input int out_stall);
        logic [31:0] exp_wb;
        logic        exp_rw;
        logic        exp_err;
        exp_err = me && err;
        exp_rw  = rw && !exp_err;
        if (exp_err)
            exp_wb = 32'd0;
        else if (me && !we)
            exp_wb = ref_load(word, f3, addr);
        else
            exp_wb = alu;

        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_inst_valid = iv; in_mem_en = me; in_mem_wen = we;
        in_funct3 = f3; in_addr = addr; in_wdata = wd; in_alu_result = alu;
        in_rd_addr = rd; in_reg_wen = rw; in_pc_target = pc;
        @(negedge clk);
        in_valid = 1'b0; in_inst_valid = 1'b0; in_addr = $urandom; in_alu_result = $urandom;
        in_wdata = $urandom; in_pc_target = $urandom;

        if (!iv) begin
            chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
            chk("bubble_req_valid", {31'd0, mem_req_valid}, 32'd0);
            chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
            return;
        end

        if (me) begin
            for (int i = 0; i <= req_stall; i++) begin
                chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
                chk("req_wen", {31'd0, mem_req_wen}, {31'd0, we});
                chk("req_wstrb", {28'd0, mem_req_wstrb}, we ? {28'd0, ref_strb(f3, addr)} : 32'd0);
                if (we) chk("req_wdata", mem_req_wdata, ref_wdata(f3, wd));
                chk("req_in_ready", {31'd0, in_ready}, 32'd0);
                chk("req_out_valid", {31'd0, out_valid}, 32'd0);
                if (i == req_stall) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= resp_dly; i++) begin
                chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
                chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
                chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
                if (i == resp_dly) begin
                    mem_resp_valid = 1'b1; mem_resp_rdata = word; mem_resp_err = err;
                end
                @(negedge clk);
            end
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'b0;
        end

        for (int i = 0; i <= out_stall; i++) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_payload_valid", {31'd0, out_payload_valid}, 32'd1);
            chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, rd});
            chk("out_wb_data", out_wb_data, exp_wb);
            chk("out_reg_wen", {31'd0, out_reg_wen}, {31'd0, exp_rw});
            chk("out_pc_target", out_pc_target, pc);
            chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
            chk("out_in_ready", {31'd0, in_ready}, 32'd0);
            chk("out_req_valid", {31'd0, mem_req_valid}, 32'd0);
            if (i == out_stall) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("after_fire_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_fire_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst_valid = 1'b0; in_mem_en = 1'b0; in_mem_wen = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_alu_result = 32'd0;
        in_rd_addr = 5'd0; in_reg_wen = 1'b0; in_pc_target = 32'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0; mem_resp_err = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_payload_valid", {31'd0, out_payload_valid}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_wb_data", out_wb_data, 32'd0);
        chk("rst_pc_target", out_pc_target, 32'd0);

        // Non-memory op
        run_inst(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h1234, 5'd5, 1'b1, 32'h100,
                 32'd0, 1'b0, 0, 0, 0);

        // Byte/half loads from word 0x80FF7F01
        run_inst(1'b1, 1'b1, 1'b0, 3'd0, 32'h1003, 32'd0, 32'h0, 5'd6, 1'b1, 32'h104,
                 32'h80FF7F01, 1'b0, 0, 0, 0);
        run_inst(1'b1, 1'b1, 1'b0, 3'd4, 32'h1003, 32'd0, 32'h0, 5'd7, 1'b1, 32'h108,
                 32'h80FF7F01, 1'b0, 0, 0, 0);
        run_inst(1'b1, 1'b1, 1'b0, 3'd1, 32'h1002, 32'd0, 32'h0, 5'd8, 1'b1, 32'h10C,
                 32'h80FF7F01, 1'b0, 0, 0, 0);
        chk("lh_literal", out_wb_data, 32'hFFFF80FF);

        // Stores
        run_inst(1'b1, 1'b1, 1'b1, 3'd0, 32'h2001, 32'h000000AB, 32'h55, 5'd0, 1'b0, 32'h110,
                 32'd0, 1'b0, 0, 0, 0);
        run_inst(1'b1, 1'b1, 1'b1, 3'd1, 32'h2002, 32'h1234BEEF, 32'h66, 5'd0, 1'b0, 32'h114,
                 32'd0, 1'b0, 0, 0, 0);

        // Stalls on request, response and output
        run_inst(1'b1, 1'b1, 1'b0, 3'd2, 32'h3004, 32'd0, 32'h0, 5'd9, 1'b1, 32'h118,
                 32'hCAFEF00D, 1'b0, 3, 2, 4);

        // Bubble, then a load with a bus error
        run_inst(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h77, 5'd3, 1'b1, 32'h11C,
                 32'd0, 1'b0, 0, 0, 0);
        run_inst(1'b1, 1'b1, 1'b0, 3'd2, 32'h4000, 32'd0, 32'h0, 5'd10, 1'b1, 32'h120,
                 32'hDEADBEEF, 1'b1, 0, 1, 0);

        // Reset while waiting for a load response
        @(negedge clk);
        in_valid = 1'b1; in_inst_valid = 1'b1; in_mem_en = 1'b1; in_mem_wen = 1'b0;
        in_funct3 = 3'd2; in_addr = 32'h5000; in_reg_wen = 1'b1; in_rd_addr = 5'd11;
        @(negedge clk);
        in_valid = 1'b0; in_inst_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_payload_valid", {31'd0, out_payload_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678; mem_resp_err = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        chk("late_resp_out_valid", {31'd0, out_valid}, 32'd0);
        chk("late_resp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("late_resp_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        chk("late_resp_out_valid2", {31'd0, out_valid}, 32'd0);
        run_inst(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h9ABC, 5'd12, 1'b1, 32'h124,
                 32'd0, 1'b0, 0, 0, 1);

        // Randomized instructions against the reference model
        for (int k = 0; k < 40; k++) begin
            r_iv   = ($urandom_range(0, 7) != 0);
            r_me   = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = r_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            r_addr = $urandom;
            r_wd   = $urandom;
            r_alu  = $urandom;
            r_rd   = 5'($urandom_range(0, 31));
            r_rw   = 1'($urandom_range(0, 1));
            r_pc   = $urandom;
            r_word = $urandom;
            r_err  = ($urandom_range(0, 5) == 0);
            run_inst(r_iv, r_me, r_we, r_f3, r_addr, r_wd, r_alu, r_rd, r_rw, r_pc, r_word, r_err,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
